estagio_id_ex: RTL and testbench
================================

Name: estagio_id_ex

Overview:
- ID/EX pipeline register with integrated load-use hazard detection.
- Captures decoded operands, register indices and control bits from ID each cycle.
- Presents rs1/rs2 indices to the forwarding unit as entrada1EX/entrada2EX, and rd/data/control to EX.
- Generates PC and IF/ID write-enables; inserts bubbles on load-use hazards, branch flush and memory stall.

Parameters:
- XLEN, 32, datapath width.
- PERF_W, 16, width of the bubble counter.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- id_valid  input  1  ID stage holds a real instruction.
- id_pc  input  XLEN  PC of the ID instruction.
- id_rs1_data  input  XLEN  register-file read 1.
- id_rs2_data  input  XLEN  register-file read 2.
- id_imm  input  XLEN  sign-extended immediate.
- id_rs1, id_rs2, id_rd  input  5 each  register indices.
- id_ctrl  input  8  control bits: [7]RegWrite [6]MemRead [5]MemWrite [4]MemToReg [3]ALUSrc [2]Branch [1:0]ALUOp.
- flush_ex  input  1  branch taken/redirect resolved in EX; squash ID instruction.
- mem_stall  input  1  memory stage not ready; freeze front of pipe.
- ex_valid  output  1  EX instruction valid.
- ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  output  XLEN each  registered copies.
- entrada1EX, entrada2EX  output  5 each  registered rs1/rs2 to forwarding unit.
- ex_rd  output  5  registered destination.
- ex_ctrl  output  8  registered control, same bit map as id_ctrl.
- pc_write  output  1  PC update enable (combinational).
- ifid_write  output  1  IF/ID register write enable (combinational).
- bubble_count  output  PERF_W  bubbles inserted since reset.

Behaviour:
- Reset (rst_n=0, asynchronous): every registered output is 0, ex_valid=0, bubble_count=0; no dependence on clk. Deassertion takes effect at the next rising edge.
- Hazard (combinational):
  - haz = id_valid & ex_valid & ex_ctrl[6] & (ex_rd!=0) & ((ex_rd==id_rs1)|(ex_rd==id_rs2)).
  - x0 never triggers a hazard.
- Priority per cycle: mem_stall > flush_ex > haz > normal.
- mem_stall=1:
  - All ID/EX registers hold their values.
  - pc_write=0, ifid_write=0.
  - bubble_count unchanged.
  - flush_ex is ignored this cycle; the source holds flush_ex until mem_stall drops.
- flush_ex=1 (no mem_stall):
  - Next edge loads a bubble: ex_valid=0, ex_ctrl=0, ex_rd=0, entrada1EX=0, entrada2EX=0.
  - Data fields, pc and imm are don't-care; they load 0.
  - pc_write=1, ifid_write=1 (the fetch unit redirects the PC).
  - haz is suppressed in this cycle.
  - bubble_count increments.
- haz=1 (no mem_stall, no flush):
  - Next edge loads a bubble as above.
  - pc_write=0, ifid_write=0, so the ID instruction is replayed next cycle.
  - bubble_count increments.
  - Hazard lasts exactly 1 cycle, because after the bubble ex_ctrl[6]=0.
- Normal:
  - Next edge loads all id_* fields.
  - ex_valid=id_valid; ex_ctrl=id_valid?id_ctrl:0.
  - pc_write=1, ifid_write=1.
- Latency: ID→EX is exactly 1 cycle; no combinational path from id_* data to ex_* outputs.
- bubble_count saturates at 2^PERF_W-1; it does not wrap.
- Reset mid-stall clears the register; the pipeline resumes with ex_valid=0.

Test Plan:
- Reset: rst_n=0 asserted between edges → all outputs 0 immediately; rst_n=1, id_valid=1, id_rd=5, id_ctrl=8'h80 → after 1 edge ex_rd=5, ex_ctrl=8'h80, ex_valid=1.
- Load-use: EX holds lw x3 (ex_ctrl[6]=1, ex_rd=3); ID add x4,x3,x1 → pc_write=0, ifid_write=0; next edge ex_ctrl=0, ex_valid=0, bubble_count=1; following edge ex_rd=4, entrada1EX=3, entrada2EX=1.
- x0 guard: EX lw x0, ID uses rs1=0 → haz=0, pc_write=1, no bubble inserted.
- Flush vs hazard: load-use condition with flush_ex=1 in the same cycle → pc_write=1, ifid_write=1; next edge bubble; bubble_count increments by 1 (not 2).
- mem_stall: assert for 3 cycles with changing id_* values → ex_* outputs constant, pc_write=ifid_write=0, bubble_count unchanged; release → normal load on the next edge.
- Saturation (PERF_W=4): force 20 consecutive hazards/flushes → bubble_count stops at 15.

Source files
------------

// File: rtl/estagio_id_ex.sv
// ID/EX pipeline register with load-use hazard detection and bubble insertion.
// Ports: id_* from decode, flush_ex/mem_stall controls, ex_* to EX, pc/ifid write enables, bubble_count.
module estagio_id_ex #(
    parameter int XLEN   = 32,
    parameter int PERF_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        id_rd,
    input  logic [7:0]        id_ctrl,
    input  logic              flush_ex,
    input  logic              mem_stall,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_rs1_data,
    output logic [XLEN-1:0]   ex_rs2_data,
    output logic [XLEN-1:0]   ex_imm,
    output logic [4:0]        entrada1EX,
    output logic [4:0]        entrada2EX,
    output logic [4:0]        ex_rd,
    output logic [7:0]        ex_ctrl,
    output logic              pc_write,
    output logic              ifid_write,
    output logic [PERF_W-1:0] bubble_count
);

    logic haz;
    logic bubble;

    // Load in EX whose destination feeds the ID instruction; x0 never counts.
    assign haz = id_valid & ex_valid & ex_ctrl[6] & (ex_rd != 5'd0)
               & ((ex_rd == id_rs1) | (ex_rd == id_rs2));

    // A flush wins over a hazard; both produce one bubble.
    assign bubble = ~mem_stall & (flush_ex | haz);

    // Front end advances unless stalled or replaying the load-use consumer.
    assign pc_write   = ~mem_stall & (flush_ex | ~haz);
    assign ifid_write = ~mem_stall & (flush_ex | ~haz);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            entrada1EX  <= '0;
            entrada2EX  <= '0;
            ex_rd       <= '0;
            ex_ctrl     <= '0;
        end else if (mem_stall) begin
            ex_valid    <= ex_valid;
        end else if (bubble) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            entrada1EX  <= '0;
            entrada2EX  <= '0;
            ex_rd       <= '0;
            ex_ctrl     <= '0;
        end else begin
            ex_valid    <= id_valid;
            ex_pc       <= id_pc;
            ex_rs1_data <= id_rs1_data;
            ex_rs2_data <= id_rs2_data;
            ex_imm      <= id_imm;
            entrada1EX  <= id_rs1;
            entrada2EX  <= id_rs2;
            ex_rd       <= id_rd;
            ex_ctrl     <= id_valid ? id_ctrl : 8'd0;
        end
    end

    // Saturating counter so long runs never wrap back to small values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_count <= '0;
        end else if (bubble && (bubble_count != '1)) begin
            bubble_count <= bubble_count + PERF_W'(1);
        end
    end

endmodule

// File: tb/tb_estagio_id_ex.sv
// Testbench for estagio_id_ex: directed scenarios plus random traffic
// checked against a cycle-level behavioural model of the pipeline register.
module tb_estagio_id_ex;

    localparam int XLEN   = 32;
    localparam int PERF_W = 4;
    localparam int SAT    = (1 << PERF_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              id_valid;
    logic [XLEN-1:0]   id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]        id_rs1, id_rs2, id_rd;
    logic [7:0]        id_ctrl;
    logic              flush_ex, mem_stall;
    logic              ex_valid;
    logic [XLEN-1:0]   ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]        entrada1EX, entrada2EX, ex_rd;
    logic [7:0]        ex_ctrl;
    logic              pc_write, ifid_write;
    logic [PERF_W-1:0] bubble_count;

    always #5 clk = ~clk;

    estagio_id_ex #(.XLEN(XLEN), .PERF_W(PERF_W)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_ctrl(id_ctrl), .flush_ex(flush_ex), .mem_stall(mem_stall),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
        .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
        .entrada1EX(entrada1EX), .entrada2EX(entrada2EX), .ex_rd(ex_rd),
        .ex_ctrl(ex_ctrl), .pc_write(pc_write), .ifid_write(ifid_write),
        .bubble_count(bubble_count)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference state: what EX should hold, as plain values.
    bit        m_valid;
    int        m_pc, m_d1, m_d2, m_imm;
    int        m_rs1, m_rs2, m_rd, m_ctrl;
    int        m_bc;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_clear();
        m_valid = 0; m_pc = 0; m_d1 = 0; m_d2 = 0; m_imm = 0;
        m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_ctrl = 0; m_bc = 0;
    endfunction

    function automatic bit model_haz();
        bit is_load;
        is_load = m_valid && ((m_ctrl / 64) % 2 == 1);
        return id_valid && is_load && m_rd != 0
            && (m_rd == int'(id_rs1) || m_rd == int'(id_rs2));
    endfunction

    task automatic check_regs(input string p);
        chk({p, ".ex_valid"}, longint'(ex_valid), longint'(m_valid));
        chk({p, ".ex_pc"}, longint'(ex_pc), longint'(unsigned'(m_pc)));
        chk({p, ".ex_rs1_data"}, longint'(ex_rs1_data),
            longint'(unsigned'(m_d1)));
        chk({p, ".ex_rs2_data"}, longint'(ex_rs2_data),
            longint'(unsigned'(m_d2)));
        chk({p, ".ex_imm"}, longint'(ex_imm), longint'(unsigned'(m_imm)));
        chk({p, ".entrada1EX"}, longint'(entrada1EX), longint'(m_rs1));
        chk({p, ".entrada2EX"}, longint'(entrada2EX), longint'(m_rs2));
        chk({p, ".ex_rd"}, longint'(ex_rd), longint'(m_rd));
        chk({p, ".ex_ctrl"}, longint'(ex_ctrl), longint'(m_ctrl));
        chk({p, ".bubble_count"}, longint'(bubble_count), longint'(m_bc));
    endtask

    // One clock: check the enables against the model, advance model and DUT.
    task automatic step(input string p);
        bit h, kill;
        #1;
        h    = model_haz();
        kill = !mem_stall && (flush_ex || h);
        chk({p, ".pc_write"}, longint'(pc_write),
            longint'(!mem_stall && (flush_ex || !h)));
        chk({p, ".ifid_write"}, longint'(ifid_write),
            longint'(!mem_stall && (flush_ex || !h)));
        if (mem_stall) begin
        end else if (kill) begin
            m_valid = 0; m_pc = 0; m_d1 = 0; m_d2 = 0; m_imm = 0;
            m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_ctrl = 0;
            m_bc = (m_bc < SAT) ? m_bc + 1 : SAT;
        end else begin
            m_valid = id_valid;
            m_pc = int'(id_pc); m_d1 = int'(id_rs1_data);
            m_d2 = int'(id_rs2_data); m_imm = int'(id_imm);
            m_rs1 = int'(id_rs1); m_rs2 = int'(id_rs2); m_rd = int'(id_rd);
            m_ctrl = id_valid ? int'(id_ctrl) : 0;
        end
        @(posedge clk);
        #1;
        check_regs(p);
    endtask

    task automatic drive(input bit v, input int rs1, input int rs2,
                         input int rd, input int ctrl,
                         input bit fl, input bit st);
        id_valid    = v;
        id_pc       = $urandom;
        id_rs1_data = $urandom;
        id_rs2_data = $urandom;
        id_imm      = $urandom;
        id_rs1      = 5'(rs1);
        id_rs2      = 5'(rs2);
        id_rd       = 5'(rd);
        id_ctrl     = 8'(ctrl);
        flush_ex    = fl;
        mem_stall   = st;
    endtask

    initial begin
        logic [XLEN-1:0] hold_pc;
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        model_clear();
        #1;
        check_regs("reset0");

        // Release between edges, then load one instruction.
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 0, 0, 5, 8'h80, 0, 0);
        step("first");
        chk("first.rd", longint'(ex_rd), 5);
        chk("first.ctrl", longint'(ex_ctrl), 8'h80);
        chk("first.valid", longint'(ex_valid), 1);

        // Asynchronous reset mid-cycle clears at once.
        #2 rst_n = 1'b0;
        #1;
        model_clear();
        check_regs("async_rst");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Load-use: lw x3 then add x4,x3,x1.
        drive(1, 2, 0, 3, 8'hD0, 0, 0);
        step("lw");
        drive(1, 3, 1, 4, 8'h82, 0, 0);
        #1;
        chk("lu.pc_write", longint'(pc_write), 0);
        chk("lu.ifid_write", longint'(ifid_write), 0);
        step("lu_bubble");
        chk("lu.ctrl", longint'(ex_ctrl), 0);
        chk("lu.valid", longint'(ex_valid), 0);
        chk("lu.bc", longint'(bubble_count), 1);
        step("lu_replay");
        chk("lu.rd", longint'(ex_rd), 4);
        chk("lu.e1", longint'(entrada1EX), 3);
        chk("lu.e2", longint'(entrada2EX), 1);

        // x0 guard: lw x0 followed by a use of x0.
        drive(1, 1, 0, 0, 8'hD0, 0, 0);
        step("lw_x0");
        drive(1, 0, 0, 6, 8'h82, 0, 0);
        #1;
        chk("x0.pc_write", longint'(pc_write), 1);
        step("x0_use");
        chk("x0.rd", longint'(ex_rd), 6);
        chk("x0.bc", longint'(bubble_count), 1);

        // Flush and hazard together: one bubble, front end still advances.
        drive(1, 1, 2, 7, 8'hD0, 0, 0);
        step("lw_x7");
        drive(1, 7, 7, 8, 8'h82, 1, 0);
        #1;
        chk("fh.pc_write", longint'(pc_write), 1);
        chk("fh.ifid_write", longint'(ifid_write), 1);
        step("fh");
        chk("fh.bc", longint'(bubble_count), 2);
        chk("fh.valid", longint'(ex_valid), 0);

        // Memory stall for three cycles with changing ID inputs.
        drive(1, 9, 10, 11, 8'h88, 0, 0);
        step("pre_stall");
        hold_pc = ex_pc;
        for (int i = 0; i < 3; i++) begin
            drive(1, i + 1, i + 2, i + 12, 8'hA0, i == 1, 1);
            #1;
            chk("st.pc_write", longint'(pc_write), 0);
            step("stall");
            chk("st.pc", longint'(ex_pc), longint'(hold_pc));
            chk("st.bc", longint'(bubble_count), 2);
        end
        drive(1, 13, 14, 15, 8'h84, 0, 0);
        step("release");
        chk("rel.rd", longint'(ex_rd), 15);

        // Saturation: twenty flushes in a row.
        for (int i = 0; i < 20; i++) begin
            drive(1, 1, 2, 3, 8'h80, 1, 0);
            step("sat");
        end
        chk("sat.bc", longint'(bubble_count), SAT);

        // Random traffic; small register indices make hazards common.
        for (int i = 0; i < 400; i++) begin
            if (i % 97 == 50) begin
                drive(1, 1, 1, 1, 8'hD0, 0, 1);
                #2 rst_n = 1'b0;
                #1;
                model_clear();
                check_regs("rst_stall");
                rst_n = 1'b1;
                @(posedge clk);
                #1;
            end
            drive($urandom_range(0, 9) < 8,
                  $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 255),
                  $urandom_range(0, 9) < 1, $urandom_range(0, 9) < 2);
            step("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
